// File: rtl/conv_stream_param.sv
// Streaming valid-mode convolver: loads N x samples and M taps, then streams N-M+1 sums.
// Optional macro CONV_STREAM_RELU_EN clamps negative results to zero before output.
module conv_stream_param #(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int OW = 2*W + $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  s_data_in_x,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    input  logic [W-1:0]  s_data_in_f,
    input  logic          s_valid_f,
    output logic          s_ready_f,
    output logic [OW-1:0] m_data_out_y,
    output logic          m_valid_y,
    input  logic          m_ready_y
);

    localparam int XAW = (N > 1) ? $clog2(N) : 1;
    localparam int FAW = (M > 1) ? $clog2(M) : 1;
    localparam int XCW = $clog2(N + 1);
    localparam int FCW = $clog2(M + 1);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t                state_q;
    logic [XCW-1:0]        xCnt_q, xCnt_d;
    logic [FCW-1:0]        fCnt_q, fCnt_d;
    logic [XCW-1:0]        outIdx_q;
    logic [FCW-1:0]        rdCnt_q;
    logic [FCW-1:0]        accCnt_q;
    logic                  rdValid_q;
    logic signed [OW-1:0]  acc_q;
    logic signed [OW-1:0]  mData_q;
    logic                  mValid_q;
    logic                  sReadyX_q;
    logic                  sReadyF_q;

    logic signed [W-1:0]   xRam [N];
    logic signed [W-1:0]   fRam [M];
    logic signed [W-1:0]   xRd_q;
    logic signed [W-1:0]   fRd_q;

    logic                  xAccept, fAccept, issue, lastTap;
    logic [XAW-1:0]        xRdAddr;
    logic [FAW-1:0]        fRdAddr;
    logic signed [2*W-1:0] prod;
    logic signed [OW-1:0]  prodExt;
    logic signed [OW-1:0]  sum_d;
    logic signed [OW-1:0]  result_d;

    assign s_ready_x    = sReadyX_q;
    assign s_ready_f    = sReadyF_q;
    assign m_valid_y    = mValid_q;
    assign m_data_out_y = mData_q;

    // The ready flags are only ever high in LOAD, so a handshake implies a write slot.
    always_comb begin
        xAccept  = s_valid_x && sReadyX_q;
        fAccept  = s_valid_f && sReadyF_q;
        xCnt_d   = xCnt_q + XCW'(xAccept);
        fCnt_d   = fCnt_q + FCW'(fAccept);
        issue    = (state_q == COMPUTE) && (rdCnt_q != FCW'(M));
        lastTap  = (accCnt_q == FCW'(M - 1));
        xRdAddr  = XAW'(outIdx_q + XCW'(rdCnt_q));
        fRdAddr  = rdCnt_q[FAW-1:0];
        prod     = xRd_q * fRd_q;
        prodExt  = prod;
        sum_d    = acc_q + prodExt;
`ifdef CONV_STREAM_RELU_EN
        result_d = sum_d[OW-1] ? '0 : sum_d;
`else
        result_d = sum_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (xAccept) xRam[xCnt_q[XAW-1:0]] <= s_data_in_x;
        if (fAccept) fRam[fCnt_q[FAW-1:0]] <= s_data_in_f;
        if (issue) begin
            xRd_q <= xRam[xRdAddr];
            fRd_q <= fRam[fRdAddr];
        end
    end

    // Reads are issued one tap per cycle; rdValid_q marks the pair arriving a cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            xCnt_q    <= '0;
            fCnt_q    <= '0;
            outIdx_q  <= '0;
            rdCnt_q   <= '0;
            accCnt_q  <= '0;
            rdValid_q <= 1'b0;
            acc_q     <= '0;
            mData_q   <= '0;
            mValid_q  <= 1'b0;
            sReadyX_q <= 1'b0;
            sReadyF_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    xCnt_q    <= xCnt_d;
                    fCnt_q    <= fCnt_d;
                    sReadyX_q <= (xCnt_d != XCW'(N));
                    sReadyF_q <= (fCnt_d != FCW'(M));
                    if ((xCnt_d == XCW'(N)) && (fCnt_d == FCW'(M))) begin
                        state_q   <= COMPUTE;
                        rdCnt_q   <= '0;
                        accCnt_q  <= '0;
                        acc_q     <= '0;
                        rdValid_q <= 1'b0;
                    end
                end
                COMPUTE: begin
                    rdValid_q <= issue;
                    if (issue) rdCnt_q <= rdCnt_q + 1'b1;
                    if (rdValid_q) begin
                        acc_q    <= sum_d;
                        accCnt_q <= accCnt_q + 1'b1;
                        if (lastTap) begin
                            mData_q  <= result_d;
                            mValid_q <= 1'b1;
                            state_q  <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        mValid_q <= 1'b0;
                        if (outIdx_q != XCW'(N - M)) begin
                            outIdx_q <= outIdx_q + 1'b1;
                            rdCnt_q  <= '0;
                            accCnt_q <= '0;
                            acc_q    <= '0;
                            state_q  <= COMPUTE;
                        end else begin
                            outIdx_q  <= '0;
                            xCnt_q    <= '0;
                            fCnt_q    <= '0;
                            sReadyX_q <= 1'b1;
                            sReadyF_q <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_param.sv
// Scoreboard bench for conv_stream_param: a default 8x4 instance plus a 4x4 single-output instance.
module tb_conv_stream_param;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int M  = 4;
    localparam int OW = 2*W + $clog2(M);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [W-1:0]         xData, fData;
    logic                 xValid, fValid, xReady, fReady;
    logic signed [OW-1:0] yData;
    logic                 yValid, yReady;

    logic [W-1:0]         bXData, bFData;
    logic                 bValid, bXReady, bFReady;
    logic signed [OW-1:0] bYData;
    logic                 bYValid, bYReady;

    conv_stream_param #(.W(W), .N(N), .M(M), .OW(OW)) dut (
        .clk(clk), .reset(reset),
        .s_data_in_x(xData), .s_valid_x(xValid), .s_ready_x(xReady),
        .s_data_in_f(fData), .s_valid_f(fValid), .s_ready_f(fReady),
        .m_data_out_y(yData), .m_valid_y(yValid), .m_ready_y(yReady)
    );

    conv_stream_param #(.W(W), .N(4), .M(4), .OW(OW)) dutSmall (
        .clk(clk), .reset(reset),
        .s_data_in_x(bXData), .s_valid_x(bValid), .s_ready_x(bXReady),
        .s_data_in_f(bFData), .s_valid_f(bValid), .s_ready_f(bFReady),
        .m_data_out_y(bYData), .m_valid_y(bYValid), .m_ready_y(bYReady)
    );

    int     errCnt = 0;
    int     chkCnt = 0;
    int     popCnt = 0;
    int     sinkMode = 0;
    longint expQ[$];
    longint expQB[$];
    int     jobX[N];
    int     jobF[M];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        chkCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    function automatic longint model(input int i);
        longint s = 0;
        for (int j = 0; j < M; j++) s += longint'(jobX[i+j]) * longint'(jobF[j]);
`ifdef CONV_STREAM_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Sink ready pattern: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        yReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sinkMode)
                0:       yReady = 1'b1;
                1:       yReady = 1'($urandom_range(1, 0));
                default: yReady = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (yValid && yReady) begin
                checkOutput("outAvail", expQ.size() > 0, 1);
                if (expQ.size() > 0) checkOutput("yData", yData, expQ.pop_front());
                popCnt++;
            end
            if (bYValid && bYReady) begin
                checkOutput("smallAvail", expQB.size() > 0, 1);
                if (expQB.size() > 0) checkOutput("smallY", bYData, expQB.pop_front());
            end
        end
    end

    task automatic sendWord(input bit isF, input int v, input int gapMax);
        int t = 0;
        int gaps = $urandom_range(gapMax, 0);
        repeat (gaps) begin @(posedge clk); #1; end
        if (isF) begin fValid = 1'b1; fData = W'(v); end
        else     begin xValid = 1'b1; xData = W'(v); end
        @(negedge clk);
        while (!(isF ? fReady : xReady) && t < 500) begin @(negedge clk); t++; end
        checkOutput(isF ? "fAccept" : "xAccept", isF ? fReady : xReady, 1);
        @(posedge clk);
        #1;
        if (isF) begin fValid = 1'b0; fData = 'x; end
        else     begin xValid = 1'b0; xData = 'x; end
    endtask

    task automatic applyStimulus(input int gapMax, input int fLead);
        @(posedge clk);
        #1;
        for (int i = 0; i <= N - M; i++) expQ.push_back(model(i));
        if (fLead > 0) begin
            for (int j = 0; j < M; j++) sendWord(1'b1, jobF[j], gapMax);
            repeat (fLead) begin @(posedge clk); #1; end
            for (int i = 0; i < N; i++) sendWord(1'b0, jobX[i], gapMax);
        end else begin
            fork
                begin for (int i = 0; i < N; i++) sendWord(1'b0, jobX[i], gapMax); end
                begin for (int j = 0; j < M; j++) sendWord(1'b1, jobF[j], gapMax); end
            join
        end
    endtask

    task automatic waitDrain(input string tag);
        int t = 0;
        while (expQ.size() != 0 && t < 3000) begin @(posedge clk); t++; end
        checkOutput(tag, expQ.size(), 0);
    endtask

    task automatic loadBasic();
        jobX = '{10, -20, 30, -40, 50, 60, 70, 80};
        jobF = '{10, 20, -30, 40};
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt, t, changes, readyHi, validDrop, base;
        logic signed [OW-1:0] held;
        longint sExp;
        int sx[4];
        int sf[4];

        reset = 1'b1;
        xValid = 1'b0; fValid = 1'b0; xData = 'x; fData = 'x;
        bValid = 1'b0; bXData = 'x; bFData = 'x; bYReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReadyX", xReady, 0);
        checkOutput("rstReadyF", fReady, 0);
        checkOutput("rstValid", yValid, 0);
        checkOutput("rstData", yData, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("readyRiseX", xReady, 1);
        checkOutput("readyRiseF", fReady, 1);

        // Basic job, everything streaming.
        loadBasic();
        sinkMode = 0;
        applyStimulus(0, 0);
        waitDrain("drainBasic");
        repeat (5) begin
            @(negedge clk);
            checkOutput("idleAfterBasic", yValid, 0);
        end

        // Random gaps on all three ports.
        jobX = '{-90, 100, -110, 120, -50, 40, 30, -20};
        jobF = '{-50, -60, 70, 80};
        sinkMode = 1;
        applyStimulus(3, 0);
        waitDrain("drainGaps");
        sinkMode = 0;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (yValid) cnt++;
        end
        checkOutput("quietAfterGaps", cnt, 0);

        // Output backpressure.
        loadBasic();
        sinkMode = 2;
        applyStimulus(0, 0);
        t = 0;
        @(negedge clk);
        while (!yValid && t < 100) begin @(negedge clk); t++; end
        checkOutput("bpValidSeen", yValid, 1);
        held = yData;
        changes = 0; readyHi = 0; validDrop = 0;
        repeat (20) begin
            @(negedge clk);
            if (yData !== held) changes++;
            if (xReady || fReady) readyHi++;
            if (!yValid) validDrop++;
        end
        checkOutput("bpDataStable", changes, 0);
        checkOutput("bpReadyLow", readyHi, 0);
        checkOutput("bpValidHeld", validDrop, 0);
        sinkMode = 0;
        waitDrain("drainBp");

        // f loaded well before x; result must follow the last x word promptly.
        jobX = '{-90, 100, -110, 120, -50, 40, 30, -20};
        jobF = '{-50, -60, 70, 80};
        applyStimulus(0, 30);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!yValid && cnt < 50);
        checkOutput("orderLatency", cnt <= M + 5, 1);
        waitDrain("drainOrder");

        // Reset in the middle of a job, then a full reload.
        loadBasic();
        base = popCnt;
        applyStimulus(0, 0);
        t = 0;
        while (popCnt < base + 2 && t < 200) begin @(negedge clk); t++; end
        checkOutput("midTwoOutputs", popCnt - base, 2);
        @(posedge clk);
        #1 reset = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midRstValid", yValid, 0);
        @(negedge clk);
        checkOutput("midRstReadyX", xReady, 1);
        checkOutput("midRstReadyF", fReady, 1);
        applyStimulus(0, 0);
        waitDrain("drainReload");

        // N=M=4 instance: exactly one output.
        sx = '{1, 2, 3, 4};
        sf = '{-1, -1, -1, -1};
        sExp = 0;
        for (int j = 0; j < 4; j++) sExp += longint'(sx[j] * sf[j]);
`ifdef CONV_STREAM_RELU_EN
        if (sExp < 0) sExp = 0;
`endif
        expQB.push_back(sExp);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bValid = 1'b1; bXData = W'(sx[i]); bFData = W'(sf[i]);
            t = 0;
            @(negedge clk);
            while (!(bXReady && bFReady) && t < 100) begin @(negedge clk); t++; end
            checkOutput("smallAccept", bXReady && bFReady, 1);
            @(posedge clk);
            #1;
        end
        bValid = 1'b0; bXData = 'x; bFData = 'x;
        t = 0;
        while (expQB.size() != 0 && t < 100) begin @(posedge clk); t++; end
        checkOutput("smallDrain", expQB.size(), 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bYValid) cnt++;
        end
        checkOutput("smallSingle", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
